ray_issue_arbiter: RTL and testbench
====================================

// Module: ray_issue_arbiter
// PURPOSE
//  Parametrised successor to the ray-march pipeline entry stage. Per frame it scans the viewport, builds primary rays
//  (camera pos + per-pixel slope) and merges them with partially-marched rays recirculating from the march stage.
//  Recirculated rays take priority. Issue is through a registered valid/ready stage feeding the march pipeline.
//  Tracks in-flight primary rays and flags frame completion when all have retired.
// PARAMETERS
//  H_DISP       1280  viewport width in pixels
//  V_DISP       720   viewport height in pixels
//  W            16    coordinate/slope word width (signed fixed point)
//  CNT_W        5     block-step counter width
//  ADDR_W       20    pixel address width (>= clog2(H_DISP*V_DISP))
//  SCALE_SHIFT  7     arithmetic right shift applied to the viewport offset
//  INFL_W       12    in-flight counter width
// PORTS
//  clk          in   1        clock
//  rst          in   1        asynchronous reset, active-low
//  frame_start  in   1        pulse; starts a frame when IDLE, ignored otherwise
//  frame_busy   out  1        high in SCAN or DRAIN
//  frame_done   out  1        one-cycle pulse when frame fully retired
//  cam_pos      in   3*W      camera position {z,y,x}, sampled at frame_start
//  vp_origin    in   3*W      signed viewport origin {z,y,x}, sampled at frame_start
//  vp_u, vp_v   in   3*W      signed viewport basis vectors {z,y,x}, sampled at frame_start
//  rec_valid    in   1        recirculated ray valid
//  rec_ready    out  1        recirculated ray accepted this cycle when rec_valid & rec_ready
//  rec_pos      in   3*W      recirculated start position {z,y,x}
//  rec_slope    in   3*W      recirculated slope {z,y,x}
//  rec_cnt      in   CNT_W    recirculated block count
//  rec_addr     in   ADDR_W   recirculated pixel address
//  retire       in   1        pulse: one primary ray terminated downstream
//  out_valid    out  1        issued ray valid
//  out_ready    in   1        march pipeline accepts
//  out_pos      out  3*W      start position {z,y,x}
//  out_slope    out  3*W      slope {z,y,x}
//  out_cnt      out  CNT_W    block count
//  out_addr     out  ADDR_W   pixel address
// BEHAVIOUR
//  - Reset: state IDLE; out_valid=0; all out_* data=0; frame_busy=0; frame_done=0; scanner x=y=0; in-flight=0;
//    latched camera/viewport regs=0. Reset mid-frame abandons the frame and discards the output register.
//  - States: IDLE -(frame_start)-> SCAN -(last pixel issued)-> DRAIN -(in-flight==0)-> IDLE, frame_done pulse same edge.
//    SCAN with zero in-flight never leaves to IDLE early; DRAIN entered even if in-flight already 0 (then done next cycle).
//  - load = !out_valid | out_ready. rec_ready = load (any state). New issue = load & !rec_valid & SCAN & in-flight!=max.
//  - On load: recirc ray copied verbatim if rec_valid, else new ray if new issue, else out_valid<=0.
//    While out_valid & !out_ready all out_* hold stable.
//  - New ray at pixel (x,y): out_pos=cam_pos, out_cnt=0, out_addr=y*H_DISP+x; uv_x=x-H_DISP/2, uv_y=y-V_DISP/2 (signed).
//    slope_c = vp_origin_c + trunc_W((vp_u_c*uv_x - vp_v_c*uv_y) >>> SCALE_SHIFT), products full 2W+1 signed, sum wraps mod 2^W.
//  - Scanner advances only on new issue: x++; at x==H_DISP-1 x<=0,y++; issue of (H_DISP-1,V_DISP-1) -> DRAIN, x=y=0.
//  - In-flight: +1 on new issue, -1 on retire, unchanged if both same cycle; retire at 0 is ignored (no underflow).
//  - Latency: frame_start at edge N -> SCAN at N+1 -> first out_valid at N+2 (out_ready held high).
// TESTING (H_DISP=4, V_DISP=2, SCALE_SHIFT=7)
//  1 Reset asserted mid-SCAN -> out_valid=0, out_* =0, frame_busy=0, next frame restarts at out_addr=0.
//  2 cam_pos=(1,2,3), u={0,0,256}, v={0,256,0}, origin={4096,0,0}, out_ready=1 -> addrs 0..7 on 8 consecutive cycles,
//    cnt=0, pixel 0 slope={x=-4,y=2,z=4096}, state DRAIN after addr 7.
//  3 rec_valid=1 for 2 cycles during SCAN -> both recirc rays forwarded unchanged, scanner stalls, next new addr continues.
//  4 out_ready=0 for 3 cycles -> out_* stable, rec_ready=0, no scanner advance; release -> stream resumes, no loss/dup.
//  5 8 retire pulses after last issue -> frame_done single pulse the cycle after count hits 0; retire+issue same cycle keeps count.
//  6 frame_start while SCAN/DRAIN -> ignored; extra retire at count 0 -> count stays 0.

Source files
------------

// File: rtl/ray_issue_arbiter.sv
// Ray-march entry stage: scans the viewport into primary rays, merges them with
// recirculated rays (recirculation wins) behind a registered valid/ready stage,
// and tracks in-flight primary rays to signal frame completion.
module ray_issue_arbiter #(
  parameter int unsigned H_DISP      = 1280,
  parameter int unsigned V_DISP      = 720,
  parameter int unsigned W           = 16,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned SCALE_SHIFT = 7,
  parameter int unsigned INFL_W      = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  output logic                frame_busy,
  output logic                frame_done,
  input  logic [3*W-1:0]      cam_pos,
  input  logic [3*W-1:0]      vp_origin,
  input  logic [3*W-1:0]      vp_u,
  input  logic [3*W-1:0]      vp_v,
  input  logic                rec_valid,
  output logic                rec_ready,
  input  logic [3*W-1:0]      rec_pos,
  input  logic [3*W-1:0]      rec_slope,
  input  logic [CNT_W-1:0]    rec_cnt,
  input  logic [ADDR_W-1:0]   rec_addr,
  input  logic                retire,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3*W-1:0]      out_pos,
  output logic [3*W-1:0]      out_slope,
  output logic [CNT_W-1:0]    out_cnt,
  output logic [ADDR_W-1:0]   out_addr
);

  localparam int unsigned XW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam int unsigned YW = (V_DISP > 1) ? $clog2(V_DISP) : 1;
  localparam int unsigned UW = W + 1;       // signed viewport offset width
  localparam int unsigned PW = 2 * W + 2;   // room for the difference of two products
  localparam int unsigned VW = 3 * W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                done_c;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [ADDR_W-1:0]   pix_addr_q;
  logic [INFL_W-1:0]   inflight_q;
  logic [VW-1:0]       cam_q, org_q, u_q, v_q;
  logic                load_c, issue_c, last_px_c, retire_eff_c;
  logic signed [UW-1:0] uv_x, uv_y;
  logic [VW-1:0]       new_slope_c;

  // One slope axis: origin + ((u*uv_x - v*uv_y) >>> SCALE_SHIFT), wrapped to W bits.
  function automatic logic [W-1:0] slope_axis(
    input logic [W-1:0]         o,
    input logic [W-1:0]         u,
    input logic [W-1:0]         v,
    input logic signed [UW-1:0] ux,
    input logic signed [UW-1:0] uy
  );
    logic signed [PW-1:0] pu, pv, acc;
    pu  = PW'($signed(u)) * PW'(ux);
    pv  = PW'($signed(v)) * PW'(uy);
    acc = (pu - pv) >>> SCALE_SHIFT;
    return o + W'(acc);
  endfunction

  assign load_c       = !out_valid || out_ready;
  assign rec_ready    = load_c;
  assign issue_c      = load_c && !rec_valid && (state_q == SCAN) && (inflight_q != '1);
  assign last_px_c    = (x_q == XW'(H_DISP - 1)) && (y_q == YW'(V_DISP - 1));
  assign retire_eff_c = retire && (inflight_q != '0);

  assign uv_x = UW'(x_q) - UW'(H_DISP / 2);
  assign uv_y = UW'(y_q) - UW'(V_DISP / 2);

  assign new_slope_c = {
    slope_axis(org_q[3*W-1:2*W], u_q[3*W-1:2*W], v_q[3*W-1:2*W], uv_x, uv_y),
    slope_axis(org_q[2*W-1:W],   u_q[2*W-1:W],   v_q[2*W-1:W],   uv_x, uv_y),
    slope_axis(org_q[W-1:0],     u_q[W-1:0],     v_q[W-1:0],     uv_x, uv_y)
  };

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Frame next-state and completion strobe.
  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE:  if (frame_start) state_d = SCAN;
      SCAN:  if (issue_c && last_px_c) state_d = DRAIN;
      DRAIN: begin
        if (inflight_q == '0) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered frame status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_busy <= (state_d != IDLE);
      frame_done <= done_c;
    end
  end

  // Camera and viewport captured when a frame is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cam_q <= '0;
      org_q <= '0;
      u_q   <= '0;
      v_q   <= '0;
    end else if ((state_q == IDLE) && frame_start) begin
      cam_q <= cam_pos;
      org_q <= vp_origin;
      u_q   <= vp_u;
      v_q   <= vp_v;
    end
  end

  // Raster scanner; advances only when a primary ray is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q        <= '0;
      y_q        <= '0;
      pix_addr_q <= '0;
    end else if (issue_c) begin
      if (last_px_c) begin
        x_q        <= '0;
        y_q        <= '0;
        pix_addr_q <= '0;
      end else if (x_q == XW'(H_DISP - 1)) begin
        x_q        <= '0;
        y_q        <= y_q + YW'(1);
        pix_addr_q <= pix_addr_q + ADDR_W'(1);
      end else begin
        x_q        <= x_q + XW'(1);
        pix_addr_q <= pix_addr_q + ADDR_W'(1);
      end
    end
  end

  // In-flight primary ray count; retire at zero is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
    end else begin
      case ({issue_c, retire_eff_c})
        2'b10:   inflight_q <= inflight_q + INFL_W'(1);
        2'b01:   inflight_q <= inflight_q - INFL_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Output register: recirculated ray first, then a new primary ray.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_slope <= '0;
      out_cnt   <= '0;
      out_addr  <= '0;
    end else if (load_c) begin
      if (rec_valid) begin
        out_valid <= 1'b1;
        out_pos   <= rec_pos;
        out_slope <= rec_slope;
        out_cnt   <= rec_cnt;
        out_addr  <= rec_addr;
      end else if (issue_c) begin
        out_valid <= 1'b1;
        out_pos   <= cam_q;
        out_slope <= new_slope_c;
        out_cnt   <= '0;
        out_addr  <= pix_addr_q;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ray_issue_arbiter.sv
// Self-checking bench for ray_issue_arbiter on a 4x2 viewport.
module tb_ray_issue_arbiter;

  localparam int unsigned H      = 4;
  localparam int unsigned V      = 2;
  localparam int unsigned W      = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned SS     = 7;
  localparam int unsigned INFL_W = 12;
  localparam int NPIX     = H * V;
  localparam int INFL_MAX = (1 << INFL_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_start, frame_busy, frame_done;
  logic [3*W-1:0] cam_pos, vp_origin, vp_u, vp_v;
  logic rec_valid, rec_ready;
  logic [3*W-1:0] rec_pos, rec_slope;
  logic [CNT_W-1:0] rec_cnt;
  logic [ADDR_W-1:0] rec_addr;
  logic retire, out_valid, out_ready;
  logic [3*W-1:0] out_pos, out_slope;
  logic [CNT_W-1:0] out_cnt;
  logic [ADDR_W-1:0] out_addr;

  always #5 clk = ~clk;

  ray_issue_arbiter #(
    .H_DISP(H), .V_DISP(V), .W(W), .CNT_W(CNT_W), .ADDR_W(ADDR_W),
    .SCALE_SHIFT(SS), .INFL_W(INFL_W)
  ) dut (
    .clk(clk), .rst(rst_n), .frame_start(frame_start), .frame_busy(frame_busy),
    .frame_done(frame_done), .cam_pos(cam_pos), .vp_origin(vp_origin), .vp_u(vp_u),
    .vp_v(vp_v), .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_pos(rec_pos),
    .rec_slope(rec_slope), .rec_cnt(rec_cnt), .rec_addr(rec_addr), .retire(retire),
    .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
    .out_slope(out_slope), .out_cnt(out_cnt), .out_addr(out_addr)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: frame phase, next pixel index, ray count, expected output register.
  int m_phase, m_pix, m_infl;
  bit m_ov, m_busy, m_done;
  logic [3*W-1:0] m_pos, m_slope, m_cam, m_org, m_u, m_v;
  logic [CNT_W-1:0] m_cnt;
  logic [ADDR_W-1:0] m_addr;

  function automatic logic [15:0] m_axis(input logic [15:0] o, input logic [15:0] u,
                                         input logic [15:0] v, input int ux, input int uy);
    longint d;
    d = longint'($signed(u)) * ux - longint'($signed(v)) * uy;
    d = d >>> SS;
    return 16'(longint'($signed(o)) + d);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pix = 0; m_infl = 0;
    m_ov = 0; m_busy = 0; m_done = 0;
    m_pos = '0; m_slope = '0; m_cnt = '0; m_addr = '0;
    m_cam = '0; m_org = '0; m_u = '0; m_v = '0;
  endtask

  task automatic model_update();
    bit load, iss;
    int old_infl, px, py;
    load = !m_ov || out_ready;
    iss  = load && !rec_valid && (m_phase == 1) && (m_infl != INFL_MAX);
    old_infl = m_infl;
    m_done = 0;
    if (load) begin
      if (rec_valid) begin
        m_ov = 1; m_pos = rec_pos; m_slope = rec_slope; m_cnt = rec_cnt; m_addr = rec_addr;
      end else if (iss) begin
        px = m_pix % H; py = m_pix / H;
        m_ov = 1; m_pos = m_cam; m_cnt = '0; m_addr = ADDR_W'(m_pix);
        for (int a = 0; a < 3; a++)
          m_slope[a*16 +: 16] = m_axis(m_org[a*16 +: 16], m_u[a*16 +: 16], m_v[a*16 +: 16],
                                       px - H / 2, py - V / 2);
      end else begin
        m_ov = 0;
      end
    end
    if (iss && !(retire && old_infl > 0)) m_infl = old_infl + 1;
    else if (!iss && retire && old_infl > 0) m_infl = old_infl - 1;
    case (m_phase)
      0: if (frame_start) begin
           m_phase = 1; m_cam = cam_pos; m_org = vp_origin; m_u = vp_u; m_v = vp_v;
         end
      1: if (iss) begin
           m_pix++;
           if (m_pix == NPIX) begin m_pix = 0; m_phase = 2; end
         end
      default: if (old_infl == 0) begin m_phase = 0; m_done = 1; end
    endcase
    m_busy = (m_phase != 0);
  endtask

  task automatic compare_model();
    chk("m_valid", 64'(out_valid), 64'(m_ov));
    chk("m_rec_ready", 64'(rec_ready), 64'(!m_ov || out_ready));
    chk("m_busy", 64'(frame_busy), 64'(m_busy));
    chk("m_done", 64'(frame_done), 64'(m_done));
    chk("m_pos", 64'(out_pos), 64'(m_pos));
    chk("m_slope", 64'(out_slope), 64'(m_slope));
    chk("m_cnt", 64'(out_cnt), 64'(m_cnt));
    chk("m_addr", 64'(out_addr), 64'(m_addr));
  endtask

  // One clock: inputs already set; model follows the edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    logic              rdy;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       sx;
    logic [15:0]       sy;
  } vec_t;

  vec_t vecs[8];
  logic [3*W-1:0] hold_pos, hold_slope, r1_pos, r1_slope, r2_pos, r2_slope;
  bit seen;

  initial begin
    vecs[0] = '{1'b1, 20'd0, 16'(-4), 16'd2};
    vecs[1] = '{1'b1, 20'd1, 16'(-2), 16'd2};
    vecs[2] = '{1'b1, 20'd2, 16'd0,   16'd2};
    vecs[3] = '{1'b1, 20'd3, 16'd2,   16'd2};
    vecs[4] = '{1'b1, 20'd4, 16'(-4), 16'd0};
    vecs[5] = '{1'b1, 20'd5, 16'(-2), 16'd0};
    vecs[6] = '{1'b1, 20'd6, 16'd0,   16'd0};
    vecs[7] = '{1'b1, 20'd7, 16'd2,   16'd0};

    rst_n = 1'b0; frame_start = 0; retire = 0; out_ready = 0;
    rec_valid = 0; rec_pos = '0; rec_slope = '0; rec_cnt = '0; rec_addr = '0;
    cam_pos = '0; vp_origin = '0; vp_u = '0; vp_v = '0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pos", 64'(out_pos), 64'd0);
    chk("rst_busy", 64'(frame_busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);

    // Frame 1: full scan with out_ready held high.
    cam_pos   = {16'd3, 16'd2, 16'd1};
    vp_u      = {16'd0, 16'd0, 16'd256};
    vp_v      = {16'd0, 16'd256, 16'd0};
    vp_origin = {16'd4096, 16'd0, 16'd0};
    out_ready = 1; frame_start = 1;
    step();
    frame_start = 0;
    chk("lat_valid", 64'(out_valid), 64'd0);
    chk("lat_busy", 64'(frame_busy), 64'd1);
    for (int i = 0; i < 8; i++) begin
      out_ready = vecs[i].rdy;
      step();
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_addr", 64'(out_addr), 64'(vecs[i].addr));
      chk("t2_sx", 64'(out_slope[15:0]), 64'(vecs[i].sx));
      chk("t2_sy", 64'(out_slope[31:16]), 64'(vecs[i].sy));
      chk("t2_sz", 64'(out_slope[47:32]), 64'd4096);
      chk("t2_cnt", 64'(out_cnt), 64'd0);
      chk("t2_pos", 64'(out_pos), 64'h0003_0002_0001);
    end
    step();
    chk("drain_idle_out", 64'(out_valid), 64'd0);
    chk("drain_busy", 64'(frame_busy), 64'd1);

    // Eight retires; done strobes one cycle after the count reaches zero.
    for (int i = 0; i < 8; i++) begin
      retire = 1;
      if (i == 3) frame_start = 1;
      step();
      frame_start = 0;
      chk("t5_no_done", 64'(frame_done), 64'd0);
    end
    retire = 0;
    chk("t5_still_busy", 64'(frame_busy), 64'd1);
    step();
    chk("t5_done", 64'(frame_done), 64'd1);
    chk("t5_idle", 64'(frame_busy), 64'd0);
    retire = 1;
    step();
    retire = 0;
    chk("t5_done_pulse", 64'(frame_done), 64'd0);

    // Frame 2: recirculation, backpressure, retire overlapping issue.
    cam_pos = {16'd7, 16'd8, 16'd9};
    frame_start = 1;
    step();
    frame_start = 0;
    step(); step();
    chk("f2_addr1", 64'(out_addr), 64'd1);
    r1_pos = 48'h1111_2222_3333; r1_slope = 48'hAAAA_BBBB_CCCC;
    r2_pos = 48'h4444_5555_6666; r2_slope = 48'hDDDD_EEEE_FFFF;
    rec_valid = 1; rec_pos = r1_pos; rec_slope = r1_slope; rec_cnt = 5'd17; rec_addr = 20'hABCDE;
    frame_start = 1;
    step();
    chk("t3_r1_pos", 64'(out_pos), 64'(r1_pos));
    chk("t3_r1_slope", 64'(out_slope), 64'(r1_slope));
    chk("t3_r1_cnt", 64'(out_cnt), 64'd17);
    chk("t3_r1_addr", 64'(out_addr), 64'hABCDE);
    rec_pos = r2_pos; rec_slope = r2_slope; rec_cnt = 5'd3; rec_addr = 20'h12345;
    step();
    chk("t3_r2_slope", 64'(out_slope), 64'(r2_slope));
    chk("t3_r2_addr", 64'(out_addr), 64'h12345);
    rec_valid = 0; frame_start = 0;
    step();
    chk("t3_resume_addr", 64'(out_addr), 64'd2);
    chk("t3_resume_pos", 64'(out_pos), 64'h0007_0008_0009);
    hold_pos = out_pos; hold_slope = out_slope;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_addr", 64'(out_addr), 64'd2);
      chk("t4_hold_slope", 64'(out_slope), 64'(hold_slope));
      chk("t4_hold_pos", 64'(out_pos), 64'(hold_pos));
      chk("t4_rec_ready", 64'(rec_ready), 64'd0);
    end
    out_ready = 1; retire = 1;
    step();
    chk("t4_release_addr", 64'(out_addr), 64'd3);
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      retire = 1;
      step();
      if (frame_done) seen = 1;
    end
    retire = 0;
    chk("f2_done_seen", 64'(seen), 64'd1);

    // Frame 3: reset in the middle of the scan.
    frame_start = 1;
    step();
    frame_start = 0;
    repeat (3) step();
    rst_n = 0;
    model_reset();
    #1;
    chk("t1_valid", 64'(out_valid), 64'd0);
    chk("t1_addr", 64'(out_addr), 64'd0);
    chk("t1_pos", 64'(out_pos), 64'd0);
    chk("t1_busy", 64'(frame_busy), 64'd0);
    step();
    rst_n = 1;
    frame_start = 1;
    step();
    frame_start = 0;
    step();
    chk("t1_restart_valid", 64'(out_valid), 64'd1);
    chk("t1_restart_addr", 64'(out_addr), 64'd0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rec_valid   = ($urandom_range(0, 4) == 0);
      rec_pos     = 48'({$urandom(), $urandom()});
      rec_slope   = 48'({$urandom(), $urandom()});
      rec_cnt     = 5'($urandom());
      rec_addr    = 20'($urandom());
      out_ready   = ($urandom_range(0, 9) < 7);
      retire      = (m_infl > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      frame_start = ($urandom_range(0, 19) == 0);
      cam_pos     = 48'({$urandom(), $urandom()});
      vp_origin   = 48'({$urandom(), $urandom()});
      vp_u        = 48'({$urandom(), $urandom()});
      vp_v        = 48'({$urandom(), $urandom()});
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
